alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised multi-cycle ALU: add, sub, iterative shift-add multiply, restoring divide.
//  start/busy/done handshake; operands latched on accept; result held until next accept.
//  Successor to the combinational add/sub ALU; sits between operand registers and result display/bus.
// PARAMETERS
//  WIDTH  6  operand width in bits (>=2); result is 2*WIDTH bits
// PORTS
//  clk    in   1         single clock, rising edge
//  rst    in   1         synchronous, active-high reset
//  start  in   1         request; accepted only when busy==0
//  a      in   WIDTH     operand A, unsigned
//  b      in   WIDTH     operand B, unsigned
//  func   in   2         00 ADD, 01 SUB, 10 MUL, 11 DIV
//  busy   out  1         high from the accept edge until the done cycle ends
//  done   out  1         one-cycle pulse: out/ovf valid
//  out    out  2*WIDTH   registered result, held after done
//  ovf    out  1         registered overflow/error flag, held with out
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, out=0, ovf=0; iteration counter and internal regs cleared.
//  - FSM: IDLE -start-> CALC -last iteration-> DONE -> IDLE. busy=1 in CALC and DONE; done=1 only in DONE.
//  - Accept at edge k latches a, b, func. done is high in the cycle after edge k+L; next start accepted at
//    edge k+L+1 (same cycle as done is legal? no: busy is high in DONE, so first accept is edge k+L+1).
//  - Latency L: ADD/SUB 1; MUL WIDTH; DIV WIDTH; DIV with b==0 is 1.
//  - start while busy: ignored, no effect on the operation in flight.
//  - ADD: out = zero-ext(a+b) (WIDTH+1 bits); ovf = carry out of bit WIDTH-1.
//  - SUB: out = a-b sign-extended to 2*WIDTH (two's complement); ovf = borrow (b>a).
//  - MUL: one partial-product add + shift per cycle, LSB of multiplier first; out = a*b; ovf=0.
//  - DIV: one restoring step per cycle, MSB first; out = {remainder, quotient}; ovf=0.
//  - DIV b==0: out = {a, {WIDTH{1'b1}}}, ovf=1.
//  - out/ovf update only on the edge entering DONE; stable otherwise (no intermediate values visible).
//  - rst mid-operation: abort, return to reset values next cycle; no done pulse for the aborted op.
//  - rst and start same edge: rst wins, start dropped.
// CONFIGURATION
//  - ALU_SEQ_DIV_EN defined: divider datapath built, DIV as above.
//  - ALU_SEQ_DIV_EN undefined: no divider logic; func 11 completes with L=1, out=0, ovf=1.
// STRUCTURE
//  - Package alu_seq_pkg: func encodings (FN_ADD/FN_SUB/FN_MUL/FN_DIV), FSM state enum (IDLE/CALC/DONE).
//  - Sub-module alu_seq_iter: shared W-step iterator (counter, accumulator/shift regs) for MUL/DIV,
//    controlled by alu_seq FSM; add/sub and result mux live in alu_seq.
//  - Counter width $clog2(WIDTH+1); all outputs driven from flops.
// TESTING (WIDTH=6, ALU_SEQ_DIV_EN defined unless noted)
//  - ADD 63+1 -> done 1 cycle after accept edge; out=12'h040, ovf=1. ADD 3+4 -> out=12'h007, ovf=0.
//  - SUB 5-9 -> out=12'hFFC, ovf=1; SUB 9-5 -> out=12'h004, ovf=0; latency 1.
//  - MUL 63*63 -> done exactly 6 cycles after accept; out=12'hF81, ovf=0; busy high throughout.
//  - DIV 45/7 -> 6 cycles; out=12'h0C6 (r=3, q=6), ovf=0; DIV 13/0 -> 1 cycle, out=12'h37F, ovf=1.
//  - start pulsed with new operands during MUL -> ignored, original product returned; rst at cycle 3 of
//    MUL -> next cycle busy=0, out=0, ovf=0, no done pulse.
//  - ALU_SEQ_DIV_EN undefined: DIV 45/7 -> 1 cycle, out=0, ovf=1; ADD/SUB/MUL unchanged.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types for the sequential ALU.
//   func_e  - operation encodings driven on the func port
//   state_e - control FSM states
package alu_seq_pkg;

    typedef enum logic [1:0] {
        FN_ADD = 2'b00,
        FN_SUB = 2'b01,
        FN_MUL = 2'b10,
        FN_DIV = 2'b11
    } func_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: shared WIDTH-step iterator for multiply and divide.
// One partial-product add + shift (MUL) or one restoring step (DIV) per step.
// The divide datapath is only built when ALU_SEQ_DIV_EN is defined.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - initialise counter and accumulator from load_a
//   step      - perform one iteration
//   div_mode  - 1: restoring divide step, 0: shift-add multiply step
//   load_a    - multiplier / dividend, captured on load
//   opb       - multiplicand / divisor, held stable by the caller
//   last      - counter is on the final iteration
//   res_next  - accumulator value after the current step
//               (MUL: product, DIV: {remainder, quotient})
module alu_seq_iter #(
    parameter int WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               div_mode,
    input  logic [WIDTH-1:0]   load_a,
    input  logic [WIDTH-1:0]   opb,
    output logic               last,
    output logic [2*WIDTH-1:0] res_next
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     hi_sum;
    logic [2*WIDTH-1:0] mul_next;

    // Multiply: acc = {partial, multiplier}; add into upper half, shift right with carry.
    always_comb begin
        hi_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb : {WIDTH{1'b0}})};
        mul_next = {hi_sum, acc_q[WIDTH-1:1]};
    end

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]     div_sh;
    logic               div_fits;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;

    // Divide: acc = {remainder, dividend/quotient}; shift in next dividend bit, trial subtract.
    always_comb begin
        div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_fits = (div_sh >= {1'b0, opb});
        div_rem  = div_fits ? (div_sh[WIDTH-1:0] - opb) : div_sh[WIDTH-1:0];
        div_next = {div_rem, acc_q[WIDTH-2:0], div_fits};
    end

    assign res_next = div_mode ? div_next : mul_next;
`else
    assign res_next = div_mode ? {2*WIDTH{1'b0}} : mul_next;
`endif

    assign last = (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (load) begin
            cnt_d = '0;
            acc_d = {{WIDTH{1'b0}}, load_a};
        end else if (step) begin
            cnt_d = cnt_q + CW'(1);
            acc_d = res_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU (add, sub, shift-add multiply, restoring divide)
// with a start/busy/done handshake. Operands are latched on accept; the
// result is held until the next operation completes.
// Config macro: ALU_SEQ_DIV_EN builds the divider; without it func 11
// completes in one cycle with out=0, ovf=1.
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset
//   start  - request, accepted only when busy is low
//   a, b   - unsigned operands (WIDTH bits)
//   func   - 00 ADD, 01 SUB, 10 MUL, 11 DIV
//   busy   - high from the accept edge until the done cycle ends
//   done   - one-cycle pulse, out/ovf valid
//   out    - registered 2*WIDTH-bit result
//   ovf    - registered overflow / error flag
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         func,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out,
    output logic               ovf
);

    state_e             state_q, state_d;
    func_e              func_q, func_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] out_q, out_d;
    logic               ovf_q, ovf_d;

    logic               it_load, it_step, it_last;
    logic [2*WIDTH-1:0] it_res_next;
    logic               iterative;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;

    alu_seq_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (it_load),
        .step     (it_step),
        .div_mode (func_q == FN_DIV),
        .load_a   (a),
        .opb      (b_q),
        .last     (it_last),
        .res_next (it_res_next)
    );

    assign add_sum  = {1'b0, a_q} + {1'b0, b_q};
    assign sub_diff = {1'b0, a_q} - {1'b0, b_q};

`ifdef ALU_SEQ_DIV_EN
    assign iterative = (func_q == FN_MUL) || ((func_q == FN_DIV) && (b_q != '0));
`else
    assign iterative = (func_q == FN_MUL);
`endif

    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        it_load = 1'b0;
        it_step = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    func_d  = func_e'(func);
                    a_d     = a;
                    b_d     = b;
                    it_load = 1'b1;
                end
            end
            CALC: begin
                if (iterative) begin
                    // Final step's result goes straight into out so the DONE edge is edge k+WIDTH.
                    it_step = 1'b1;
                    if (it_last) begin
                        state_d = DONE;
                        out_d   = it_res_next;
                        ovf_d   = 1'b0;
                    end
                end else begin
                    state_d = DONE;
                    case (func_q)
                        FN_ADD: begin
                            out_d = {{(WIDTH-1){1'b0}}, add_sum};
                            ovf_d = add_sum[WIDTH];
                        end
                        FN_SUB: begin
                            out_d = {{(WIDTH-1){sub_diff[WIDTH]}}, sub_diff};
                            ovf_d = sub_diff[WIDTH];
                        end
`ifdef ALU_SEQ_DIV_EN
                        FN_DIV: begin
                            out_d = {a_q, {WIDTH{1'b1}}};
                            ovf_d = 1'b1;
                        end
`else
                        FN_DIV: begin
                            out_d = '0;
                            ovf_d = 1'b1;
                        end
`endif
                        default: begin
                            out_d = out_q;
                            ovf_d = ovf_q;
                        end
                    endcase
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            func_q  <= FN_ADD;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=6) using directed
// vectors plus randomized operations against an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a, b;
    logic [1:0]     func;
    logic           busy, done, ovf;
    logic [2*W-1:0] out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_seq #(
        .WIDTH(W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .func  (func),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .ovf   (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: result, flag and latency straight from the arithmetic definition.
    task automatic ref_calc(input int ra, input int rb, input int rf,
                            output logic [2*W-1:0] ro, output logic rv, output int rl);
        int max_w;
        max_w = (1 << W) - 1;
        rl = 1;
        case (rf)
            0: begin ro = (2*W)'(ra + rb); rv = (ra + rb) > max_w; end
            1: begin ro = (2*W)'(ra - rb); rv = rb > ra; end
            2: begin ro = (2*W)'(ra * rb); rv = 1'b0; rl = W; end
            default: begin
`ifdef ALU_SEQ_DIV_EN
                if (rb == 0) begin
                    ro = (2*W)'((ra << W) | max_w); rv = 1'b1;
                end else begin
                    ro = (2*W)'(((ra % rb) << W) | (ra / rb)); rv = 1'b0; rl = W;
                end
`else
                ro = '0; rv = 1'b1;
`endif
            end
        endcase
    endtask

    // Issue one operation; optionally hammer start with junk while busy.
    task automatic do_op(input int ta, input int tb, input int tf, input bit poke);
        logic [2*W-1:0] e_out;
        logic           e_ovf;
        int             e_lat;
        int             cyc;
        logic [2*W-1:0] held;
        ref_calc(ta, tb, tf, e_out, e_ovf, e_lat);
        @(negedge clk);
        a = W'(ta); b = W'(tb); func = 2'(tf); start = 1'b1;
        @(posedge clk);
        cyc = 0;
        @(negedge clk);
        start = 1'b0;
        while (!done && cyc < 40) begin
            check("busy_in_calc", 32'(busy), 32'd1);
            if (poke) begin
                a = W'($urandom); b = W'($urandom); func = 2'($urandom); start = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("latency", 32'(cyc), 32'(e_lat));
        check("out", 32'(out), 32'(e_out));
        check("ovf", 32'(ovf), 32'(e_ovf));
        check("busy_in_done", 32'(busy), 32'd1);
        held = out;
        @(negedge clk);
        check("busy_after", 32'(busy), 32'd0);
        check("done_pulse", 32'(done), 32'd0);
        check("out_held", 32'(out), 32'(held));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; func = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        do_op(63, 1, 0, 1'b0);
        do_op(3, 4, 0, 1'b0);
        do_op(5, 9, 1, 1'b0);
        do_op(9, 5, 1, 1'b0);
        do_op(63, 63, 2, 1'b0);
        do_op(45, 7, 3, 1'b0);
        do_op(13, 0, 3, 1'b0);
        do_op(0, 0, 2, 1'b0);
        do_op(63, 63, 2, 1'b1);
        do_op(0, 1, 3, 1'b1);

        // Reset in the third CALC cycle of a multiply.
        @(negedge clk);
        a = 6'd37; b = 6'd29; func = 2'd2; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out", 32'(out), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < W + 2; i++) begin
            check("abort_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end

        // Reset and start on the same edge: start is dropped.
        do_op(7, 8, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 6'd1; b = 6'd2; func = 2'd0;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("rst_start_done", 32'(done), 32'd0);
        check("rst_start_out", 32'(out), 32'd0);

        for (int i = 0; i < 60; i++) begin
            do_op(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                  int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
